uart_rx: RTL

UART receive stage that is the downstream counterpart of the team's UART transmitter: it deserialises an 8N1 serial line into bytes. The line is sampled at OVERSAMPLE× the baud rate, with a 3-sample majority vote at mid-bit and start-bit validation. Each received byte is presented on a one-entry valid/ready holding register. Framing errors and overruns are reported as single-cycle pulses.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_os_tick.sv | 35 +++
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default line setup, receiver state
// encoding and the 3-sample majority helper.
package uart_pkg;

    localparam int DATA_BITS         = 8;
    localparam int DEFAULT_CLK_FREQ  = 50000000;
    localparam int DEFAULT_BAUD_RATE = 9600;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE      = 3'd0;
    localparam uart_state_t ST_START     = 3'd1;
    localparam uart_state_t ST_DATA      = 3'd2;
    localparam uart_state_t ST_STOP      = 3'd3;
    localparam uart_state_t ST_WAIT_HIGH = 3'd4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversampling tick generator: one-cycle tick every TICK_DIV clocks,
// restartable through clr so the tick phase can be tied to a line edge.
module uart_os_tick #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised, oversampled line with mid-bit majority
// voting, delivering bytes through a one-entry valid/ready holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun,
    output logic [2:0] rx_state
);

    localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int SW       = $clog2(OVERSAMPLE);

    localparam logic [SW-1:0] S_PRE  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_POST = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("uart_rx: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 1");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx: OVERSAMPLE must be even and at least 8");
    end

    // Handshake: a byte moves to the consumer on any clk edge where
    // rx_valid & rx_ready; rx_data is stable while rx_valid is high.
    logic            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]      arm_q, arm_d;
    logic            prev_q, prev_d;
    uart_state_t     state_q, state_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [1:0]      samp_q, samp_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            fe_q, fe_d;
    logic            ov_q, ov_d;

    logic tick, start_edge, fall, maj, decide, bit_end, deliver, hs;

    uart_os_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_edge),
        .tick (tick)
    );

    always_comb begin
        sync1_d   = rx;
        sync2_d   = sync1_q;
        // The synchroniser's reset value is not a real line sample, so the
        // edge register only tracks it once real data has reached sync2.
        arm_d     = {arm_q[0], 1'b1};
        prev_d    = sync2_q & arm_q[1];
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        bit_idx_d = bit_idx_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        fe_d      = 1'b0;
        ov_d      = 1'b0;
        deliver   = 1'b0;
        start_edge = 1'b0;

        fall    = prev_q & ~sync2_q;
        maj     = maj3(samp_q[0], samp_q[1], sync2_q);
        decide  = tick && (s_cnt_q == S_POST);
        bit_end = tick && (s_cnt_q == S_LAST);
        hs      = valid_q & rx_ready;

        if (tick) s_cnt_d = (s_cnt_q == S_LAST) ? '0 : s_cnt_q + SW'(1);
        if (tick && s_cnt_q == S_PRE) samp_d[0] = sync2_q;
        if (tick && s_cnt_q == S_MID) samp_d[1] = sync2_q;

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d    = ST_START;
                    start_edge = 1'b1;
                    s_cnt_d    = '0;
                end
            end
            ST_START: begin
                if (decide && maj) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (decide) shift_d = {maj, shift_q[7:1]};
                if (bit_end) begin
                    if (bit_idx_q == LAST_BIT) state_d = ST_STOP;
                    else                       bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    if (maj) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (sync2_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (deliver) begin
            if (!valid_q || hs) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (hs) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            arm_q     <= '0;
            prev_q    <= 1'b0;
            state_q   <= ST_IDLE;
            s_cnt_q   <= '0;
            bit_idx_q <= '0;
            samp_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            arm_q     <= arm_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            bit_idx_q <= bit_idx_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = (state_q != ST_IDLE);
    assign frame_err = fe_q;
    assign overrun   = ov_q;
    assign rx_state  = state_q;

endmodule
